output_serializer_32_to_1: RTL and testbench

OUTPUT_SERIALIZER_32_TO_1 -- requirements
Module: output_serializer_32_to_1

---
 rtl/output_serializer_32_to_1.sv | 154 +++++++++++++++
 tb/tb_output_serializer_32_to_1.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/output_serializer_32_to_1.sv
// 32-lane parallel-to-serial converter; SERIALIZER_PARITY_EN adds a registered out_parity output.
// Latency: lane 0 appears one cycle after a block is accepted; out_ready low holds the beat;
// a new block is accepted on the cycle the final beat is accepted, so blocks stream back to back.
module output_serializer_32_to_1 #(
    parameter int SELECT_WIDTH = 5,
    parameter int DATA_WIDTH   = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic signed [DATA_WIDTH-1:0]  in_data_0,
    input  logic signed [DATA_WIDTH-1:0]  in_data_1,
    input  logic signed [DATA_WIDTH-1:0]  in_data_2,
    input  logic signed [DATA_WIDTH-1:0]  in_data_3,
    input  logic signed [DATA_WIDTH-1:0]  in_data_4,
    input  logic signed [DATA_WIDTH-1:0]  in_data_5,
    input  logic signed [DATA_WIDTH-1:0]  in_data_6,
    input  logic signed [DATA_WIDTH-1:0]  in_data_7,
    input  logic signed [DATA_WIDTH-1:0]  in_data_8,
    input  logic signed [DATA_WIDTH-1:0]  in_data_9,
    input  logic signed [DATA_WIDTH-1:0]  in_data_10,
    input  logic signed [DATA_WIDTH-1:0]  in_data_11,
    input  logic signed [DATA_WIDTH-1:0]  in_data_12,
    input  logic signed [DATA_WIDTH-1:0]  in_data_13,
    input  logic signed [DATA_WIDTH-1:0]  in_data_14,
    input  logic signed [DATA_WIDTH-1:0]  in_data_15,
    input  logic signed [DATA_WIDTH-1:0]  in_data_16,
    input  logic signed [DATA_WIDTH-1:0]  in_data_17,
    input  logic signed [DATA_WIDTH-1:0]  in_data_18,
    input  logic signed [DATA_WIDTH-1:0]  in_data_19,
    input  logic signed [DATA_WIDTH-1:0]  in_data_20,
    input  logic signed [DATA_WIDTH-1:0]  in_data_21,
    input  logic signed [DATA_WIDTH-1:0]  in_data_22,
    input  logic signed [DATA_WIDTH-1:0]  in_data_23,
    input  logic signed [DATA_WIDTH-1:0]  in_data_24,
    input  logic signed [DATA_WIDTH-1:0]  in_data_25,
    input  logic signed [DATA_WIDTH-1:0]  in_data_26,
    input  logic signed [DATA_WIDTH-1:0]  in_data_27,
    input  logic signed [DATA_WIDTH-1:0]  in_data_28,
    input  logic signed [DATA_WIDTH-1:0]  in_data_29,
    input  logic signed [DATA_WIDTH-1:0]  in_data_30,
    input  logic signed [DATA_WIDTH-1:0]  in_data_31,
    input  logic                          load_valid,
    output logic                          load_ready,
    output logic signed [DATA_WIDTH-1:0]  out_data,
    output logic [SELECT_WIDTH-1:0]       out_select,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          out_last,
    output logic                          busy
`ifdef SERIALIZER_PARITY_EN
    ,
    output logic                          out_parity
`endif
);
    localparam int NUM_LANES = 32;
    localparam logic [SELECT_WIDTH-1:0] LAST_SEL = SELECT_WIDTH'(NUM_LANES - 1);

    typedef enum logic {IDLE, SEND} state_t;

    logic signed [DATA_WIDTH-1:0] lane_in [NUM_LANES];
    logic signed [DATA_WIDTH-1:0] bank_q  [NUM_LANES];
    logic signed [DATA_WIDTH-1:0] bank_d  [NUM_LANES];
    state_t                       state_q, state_d;
    logic signed [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic [SELECT_WIDTH-1:0]      out_select_q, out_select_d, sel_inc;
    logic                         out_valid_q, out_valid_d;
    logic                         out_last_q, out_last_d;
    logic                         beat_fire, last_fire, load_fire;

    assign lane_in[0]  = in_data_0;   assign lane_in[1]  = in_data_1;
    assign lane_in[2]  = in_data_2;   assign lane_in[3]  = in_data_3;
    assign lane_in[4]  = in_data_4;   assign lane_in[5]  = in_data_5;
    assign lane_in[6]  = in_data_6;   assign lane_in[7]  = in_data_7;
    assign lane_in[8]  = in_data_8;   assign lane_in[9]  = in_data_9;
    assign lane_in[10] = in_data_10;  assign lane_in[11] = in_data_11;
    assign lane_in[12] = in_data_12;  assign lane_in[13] = in_data_13;
    assign lane_in[14] = in_data_14;  assign lane_in[15] = in_data_15;
    assign lane_in[16] = in_data_16;  assign lane_in[17] = in_data_17;
    assign lane_in[18] = in_data_18;  assign lane_in[19] = in_data_19;
    assign lane_in[20] = in_data_20;  assign lane_in[21] = in_data_21;
    assign lane_in[22] = in_data_22;  assign lane_in[23] = in_data_23;
    assign lane_in[24] = in_data_24;  assign lane_in[25] = in_data_25;
    assign lane_in[26] = in_data_26;  assign lane_in[27] = in_data_27;
    assign lane_in[28] = in_data_28;  assign lane_in[29] = in_data_29;
    assign lane_in[30] = in_data_30;  assign lane_in[31] = in_data_31;

    // Reload is allowed in the very cycle the final beat leaves, keeping the stream gapless.
    assign beat_fire  = out_valid_q && out_ready;
    assign last_fire  = beat_fire && (out_select_q == LAST_SEL);
    assign load_ready = (state_q == IDLE) || last_fire;
    assign load_fire  = load_valid && load_ready;
    assign sel_inc    = out_select_q + 1'b1;

    always_comb begin
        state_d      = state_q;
        bank_d       = bank_q;
        out_data_d   = out_data_q;
        out_select_d = out_select_q;
        out_valid_d  = out_valid_q;
        out_last_d   = out_last_q;
        if (load_fire) begin
            bank_d       = lane_in;
            state_d      = SEND;
            out_data_d   = lane_in[0];
            out_select_d = '0;
            out_valid_d  = 1'b1;
            out_last_d   = 1'b0;
        end else if (last_fire) begin
            state_d      = IDLE;
            out_select_d = '0;
            out_valid_d  = 1'b0;
            out_last_d   = 1'b0;
        end else if (beat_fire) begin
            out_data_d   = bank_q[sel_inc];
            out_select_d = sel_inc;
            out_last_d   = (sel_inc == LAST_SEL);
        end
    end

`ifdef SERIALIZER_PARITY_EN
    logic out_parity_q, out_parity_d;
    assign out_parity_d = ^out_data_d;
    assign out_parity   = out_parity_q;

    always_ff @(posedge clk) begin
        if (reset) out_parity_q <= 1'b0;
        else       out_parity_q <= out_parity_d;
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            out_data_q   <= '0;
            out_select_q <= '0;
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
            for (int i = 0; i < NUM_LANES; i++) bank_q[i] <= '0;
        end else begin
            state_q      <= state_d;
            out_data_q   <= out_data_d;
            out_select_q <= out_select_d;
            out_valid_q  <= out_valid_d;
            out_last_q   <= out_last_d;
            bank_q       <= bank_d;
        end
    end

    assign out_data   = out_data_q;
    assign out_select = out_select_q;
    assign out_valid  = out_valid_q;
    assign out_last   = out_last_q;
    assign busy       = (state_q == SEND);
endmodule

// File: tb/tb_output_serializer_32_to_1.sv
// Bench for output_serializer_32_to_1: fixed vector table, directed streams and a queue reference model.
module tb_output_serializer_32_to_1;
    localparam int SW = 5;
    localparam int DW = 16;
    localparam int N  = 32;

    logic clk = 1'b0;
    logic reset, load_valid, out_ready;
    logic signed [DW-1:0] in_data [N];
    logic load_ready, out_valid, out_last, busy;
    logic signed [DW-1:0] out_data;
    logic [SW-1:0] out_select;
`ifdef SERIALIZER_PARITY_EN
    logic out_parity;
`endif

    always #5 clk = ~clk;

    output_serializer_32_to_1 #(.SELECT_WIDTH(SW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .reset(reset),
        .in_data_0(in_data[0]),   .in_data_1(in_data[1]),   .in_data_2(in_data[2]),   .in_data_3(in_data[3]),
        .in_data_4(in_data[4]),   .in_data_5(in_data[5]),   .in_data_6(in_data[6]),   .in_data_7(in_data[7]),
        .in_data_8(in_data[8]),   .in_data_9(in_data[9]),   .in_data_10(in_data[10]), .in_data_11(in_data[11]),
        .in_data_12(in_data[12]), .in_data_13(in_data[13]), .in_data_14(in_data[14]), .in_data_15(in_data[15]),
        .in_data_16(in_data[16]), .in_data_17(in_data[17]), .in_data_18(in_data[18]), .in_data_19(in_data[19]),
        .in_data_20(in_data[20]), .in_data_21(in_data[21]), .in_data_22(in_data[22]), .in_data_23(in_data[23]),
        .in_data_24(in_data[24]), .in_data_25(in_data[25]), .in_data_26(in_data[26]), .in_data_27(in_data[27]),
        .in_data_28(in_data[28]), .in_data_29(in_data[29]), .in_data_30(in_data[30]), .in_data_31(in_data[31]),
        .load_valid(load_valid), .load_ready(load_ready),
        .out_data(out_data), .out_select(out_select), .out_valid(out_valid),
        .out_ready(out_ready), .out_last(out_last), .busy(busy)
`ifdef SERIALIZER_PARITY_EN
        , .out_parity(out_parity)
`endif
    );

    // Reference: a queue of beats still owed downstream, each tagged with its lane index.
    typedef struct { logic signed [DW-1:0] d; int idx; } beat_t;
    beat_t mq[$];

    typedef struct {
        bit rst; bit lv; bit ordy; int fill;
        bit e_v; int e_sel; int e_d; bit e_last; bit e_rdy;
    } vec_t;
    vec_t vt[10];

    int n_chk = 0;
    int n_fail = 0;
    bit model_on = 1'b0;
    int valid_cycles;
    logic signed [DW-1:0] got[$];

    task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // kinds: 0 ramp base+k, 1 all 0x7FFF, 2 -k, 3 random, 4 lanes alternating 0x0001/0x0003
    task automatic fill(input int kind, input int base);
        for (int k = 0; k < N; k++) begin
            case (kind)
                0:       in_data[k] = DW'(base + k);
                1:       in_data[k] = 16'sh7FFF;
                2:       in_data[k] = DW'(0 - k);
                3:       in_data[k] = DW'($urandom);
                default: in_data[k] = (k % 2 == 0) ? 16'sd1 : 16'sd3;
            endcase
        end
    endtask

    task automatic model_check();
        bit exp_v;
        bit exp_rdy;
        exp_v   = (mq.size() > 0);
        exp_rdy = (mq.size() == 0) || (mq.size() == 1 && out_ready);
        chk("valid", out_valid, exp_v);
        chk("busy", busy, exp_v);
        chk("load_ready", load_ready, exp_rdy);
        if (exp_v) begin
            chk("data", out_data, mq[0].d);
            chk("select", out_select, mq[0].idx);
            chk("last", out_last, mq[0].idx == N - 1);
`ifdef SERIALIZER_PARITY_EN
            chk("parity", out_parity, ^mq[0].d);
`endif
        end else begin
            chk("last_idle", out_last, 0);
        end
    endtask

    task automatic model_edge();
        bit rdy;
        if (reset) begin
            mq.delete();
        end else begin
            rdy = (mq.size() == 0) || (mq.size() == 1 && out_ready);
            if (mq.size() > 0 && out_ready) void'(mq.pop_front());
            if (load_valid && rdy)
                for (int k = 0; k < N; k++) mq.push_back('{d: in_data[k], idx: k});
        end
    endtask

    task automatic pre();
        @(negedge clk);
        if (model_on) model_check();
        if (out_valid === 1'b1) valid_cycles++;
        if (out_valid === 1'b1 && out_ready) got.push_back(out_data);
    endtask

    task automatic post();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic check_got(input string name, input int kind, input int base, input int cnt);
        int exp;
        chk({name, "_count"}, got.size(), cnt);
        for (int i = 0; i < cnt && i < got.size(); i++) begin
            exp = (kind == 0) ? base + (i % N) : ((i < N) ? i : 0 - (i % N));
            chk(name, got[i], exp);
        end
    endtask

    initial begin
        vt[0] = '{0, 1, 0, 0, 0, 0,   0, 0, 1};
        vt[1] = '{0, 0, 0, 0, 1, 0, 100, 0, 0};
        vt[2] = '{0, 1, 0, 1, 1, 0, 100, 0, 0};
        vt[3] = '{0, 0, 1, 0, 1, 0, 100, 0, 0};
        vt[4] = '{0, 0, 1, 0, 1, 1, 101, 0, 0};
        vt[5] = '{0, 0, 0, 0, 1, 2, 102, 0, 0};
        vt[6] = '{0, 0, 1, 0, 1, 2, 102, 0, 0};
        vt[7] = '{0, 0, 1, 0, 1, 3, 103, 0, 0};
        vt[8] = '{1, 0, 1, 0, 1, 4, 104, 0, 0};
        vt[9] = '{0, 0, 1, 0, 0, 0,   0, 0, 1};

        reset = 1'b1; load_valid = 1'b0; out_ready = 1'b0; fill(0, 100);
        post(); post();
        pre();
        chk("rst_valid", out_valid, 0);
        chk("rst_last", out_last, 0);
        chk("rst_select", out_select, 0);
        chk("rst_data", out_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_load_ready", load_ready, 1);
`ifdef SERIALIZER_PARITY_EN
        chk("rst_parity", out_parity, 0);
`endif
        post();
        reset = 1'b0;

        // Vector table: capture, stall, ignored load of 0x7FFF, stepping, reset mid-block.
        foreach (vt[i]) begin
            reset = vt[i].rst; load_valid = vt[i].lv; out_ready = vt[i].ordy;
            fill(vt[i].fill, 100);
            pre();
            chk($sformatf("vec%0d_valid", i), out_valid, vt[i].e_v);
            chk($sformatf("vec%0d_busy", i), busy, vt[i].e_v);
            chk($sformatf("vec%0d_select", i), out_select, vt[i].e_sel);
            chk($sformatf("vec%0d_last", i), out_last, vt[i].e_last);
            chk($sformatf("vec%0d_load_ready", i), load_ready, vt[i].e_rdy);
            if (vt[i].e_v) chk($sformatf("vec%0d_data", i), out_data, vt[i].e_d);
            post();
        end
        reset = 1'b0; load_valid = 1'b0;
        model_on = 1'b1;

        // Full-rate stream of 100..131.
        got.delete(); valid_cycles = 0;
        fill(0, 100); load_valid = 1'b1; out_ready = 1'b1;
        pre(); post();
        load_valid = 1'b0;
        repeat (32) begin pre(); post(); end
        pre();
        chk("stream_done_valid", out_valid, 0);
        chk("stream_done_load_ready", load_ready, 1);
        post();
        check_got("stream_data", 0, 100, 32);
        chk("stream_cycles", valid_cycles, 32);

        // out_ready toggling: each element held through its stall, 63 valid cycles.
        got.delete(); valid_cycles = 0;
        load_valid = 1'b1; out_ready = 1'b0;
        pre(); post();
        load_valid = 1'b0;
        for (int c = 0; c < 70; c++) begin
            out_ready = (c % 2 == 0);
            pre(); post();
        end
        check_got("toggle_data", 0, 100, 32);
        chk("toggle_cycles", valid_cycles, 63);

        // Block A (k) then block B (-k) loaded on A's last beat: no bubble.
        fill(0, 0); load_valid = 1'b1; out_ready = 1'b1;
        pre(); post();
        load_valid = 1'b0;
        got.delete(); valid_cycles = 0;
        for (int c = 0; c < 64; c++) begin
            if (c == 31) begin fill(2, 0); load_valid = 1'b1; end
            pre(); post();
            load_valid = 1'b0;
        end
        chk("b2b_valid_cycles", valid_cycles, 64);
        check_got("b2b_data", 1, 0, 64);
        repeat (2) begin pre(); post(); end

        // Reset at out_select==10, then a fresh block starts from lane 0.
        fill(0, 100); load_valid = 1'b1; out_ready = 1'b1;
        pre(); post();
        load_valid = 1'b0;
        repeat (10) begin pre(); post(); end
        reset = 1'b1;
        pre();
        chk("pre_abort_select", out_select, 10);
        post();
        reset = 1'b0;
        pre();
        chk("abort_valid", out_valid, 0);
        chk("abort_select", out_select, 0);
        chk("abort_load_ready", load_ready, 1);
        post();
        fill(4, 0); load_valid = 1'b1;
        pre(); post();
        load_valid = 1'b0;
        pre();
        chk("restart_data", out_data, 1);
        chk("restart_select", out_select, 0);
`ifdef SERIALIZER_PARITY_EN
        chk("parity_0x0001", out_parity, 1);
`endif
        post();
        pre();
        chk("restart_data1", out_data, 3);
`ifdef SERIALIZER_PARITY_EN
        chk("parity_0x0003", out_parity, 0);
`endif
        post();

        // Random traffic against the queue model, including sporadic resets.
        for (int c = 0; c < 3000; c++) begin
            reset      = ($urandom_range(0, 199) == 0);
            load_valid = ($urandom_range(0, 1) == 1);
            out_ready  = ($urandom_range(0, 3) != 0);
            fill(3, 0);
            pre(); post();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
